// File: rtl/bus_io_pkg.sv
// Shared definitions for the memory-mapped I/O peripherals on the 8-bit processor bus.
// Holds the register offsets, the bus width and the default base address of the input port.
package bus_io_pkg;

    localparam int         BUS_W             = 8;
    localparam logic [7:0] DEFAULT_BASE_ADDR = 8'hC4;

    localparam logic [1:0] OFS_SW_LO = 2'd0;
    localparam logic [1:0] OFS_SW_HI = 2'd1;
    localparam logic [1:0] OFS_BTN   = 2'd2;
    localparam logic [1:0] OFS_MASK  = 2'd3;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus a tick-sampled history per bit; a bit's debounced level
// follows the history only once every sample in it agrees.
module input_debouncer #(
    parameter int WIDTH   = 16,
    parameter int SAMPLES = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             tick_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] db_o
);

    logic [WIDTH-1:0]   sync1_q;
    logic [WIDTH-1:0]   sync2_q;
    logic [WIDTH-1:0]   db_q;
    logic [WIDTH-1:0]   db_d;
    logic [SAMPLES-1:0] hist_q [WIDTH];

    // Synchroniser, history shift on tick, and debounced level register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            if (tick_i) begin
                for (int i = 0; i < WIDTH; i++) begin
                    hist_q[i] <= (hist_q[i] << 1) | SAMPLES'(sync2_q[i]);
                end
            end else begin
                for (int i = 0; i < WIDTH; i++) begin
                    hist_q[i] <= hist_q[i];
                end
            end
        end
    end

    // Accept a new level only when the full history is unanimous
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (&hist_q[i]) begin
                db_d[i] = 1'b1;
            end else if (~|hist_q[i]) begin
                db_d[i] = 1'b0;
            end else begin
                db_d[i] = db_q[i];
            end
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/bus_input_port.sv
// Read-side bus peripheral: debounced switches/buttons, button edge flags with W1C,
// interrupt mask and a level interrupt held until acknowledged.
module bus_input_port
    import bus_io_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR        = DEFAULT_BASE_ADDR,
    parameter int         DEBOUNCE_DIV     = 100000,
    parameter int         DEBOUNCE_SAMPLES = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       BUS_ADDR,
    inout  wire  [BUS_W-1:0] BUS_DATA,
    input  logic             BUS_WE,
    input  logic [15:0]      SWITCHES,
    input  logic [3:0]       BUTTONS,
    output logic             BUS_INTERRUPT_RAISE,
    input  logic             BUS_INTERRUPT_ACK
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tick_s;
    logic [15:0]      sw_db_s;
    logic [3:0]       btn_db_s;
    logic [3:0]       btn_prev_q;
    logic [3:0]       rise_s;
    logic [3:0]       edge_flag_q, edge_flag_d;
    logic [3:0]       irq_mask_q, irq_mask_d;
    logic             raise_q, raise_d;
    logic             drive_en_q, drive_en_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic [7:0]       offset_s;
    logic [1:0]       ofs_s;
    logic             in_range_s;
    logic             wr_s;
    logic [7:0]       rd_mux_s;
    logic [3:0]       clr_s;

    input_debouncer #(.WIDTH(16), .SAMPLES(DEBOUNCE_SAMPLES)) u_sw_db (
        .CLK(CLK), .RESET(RESET), .tick_i(tick_s), .raw_i(SWITCHES), .db_o(sw_db_s)
    );

    input_debouncer #(.WIDTH(4), .SAMPLES(DEBOUNCE_SAMPLES)) u_btn_db (
        .CLK(CLK), .RESET(RESET), .tick_i(tick_s), .raw_i(BUTTONS), .db_o(btn_db_s)
    );

    assign tick_s = (cnt_q == CNT_MAX);

    // Unsigned wrap-around subtraction keeps the range check correct near 8'hFF
    assign offset_s   = BUS_ADDR - BASE_ADDR;
    assign in_range_s = (offset_s < 8'd4);
    assign ofs_s      = offset_s[1:0];
    assign wr_s       = BUS_WE && in_range_s;
    assign rise_s     = btn_db_s & ~btn_prev_q;

    // Read data selection from current register state
    always_comb begin
        rd_mux_s = 8'h00;
        case (ofs_s)
            OFS_SW_LO: rd_mux_s = sw_db_s[7:0];
            OFS_SW_HI: rd_mux_s = sw_db_s[15:8];
            OFS_BTN:   rd_mux_s = {edge_flag_q, btn_db_s};
            OFS_MASK:  rd_mux_s = {4'b0000, irq_mask_q};
            default:   rd_mux_s = 8'h00;
        endcase
    end

    // Next-state for flags, mask, interrupt and read response
    always_comb begin
        clr_s       = (wr_s && (ofs_s == OFS_BTN)) ? BUS_DATA[7:4] : 4'h0;
        edge_flag_d = (edge_flag_q & ~clr_s) | rise_s;
        irq_mask_d  = (wr_s && (ofs_s == OFS_MASK)) ? BUS_DATA[3:0] : irq_mask_q;
        if (|(rise_s & irq_mask_q)) begin
            raise_d = 1'b1;
        end else if (BUS_INTERRUPT_ACK) begin
            raise_d = 1'b0;
        end else begin
            raise_d = raise_q;
        end
        drive_en_d = !BUS_WE && in_range_s;
        rd_data_d  = drive_en_d ? rd_mux_s : rd_data_q;
    end

    // State registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q       <= '0;
            btn_prev_q  <= 4'h0;
            edge_flag_q <= 4'h0;
            irq_mask_q  <= 4'hF;
            raise_q     <= 1'b0;
            drive_en_q  <= 1'b0;
            rd_data_q   <= 8'h00;
        end else begin
            cnt_q       <= tick_s ? '0 : cnt_q + CNT_W'(1);
            btn_prev_q  <= btn_db_s;
            edge_flag_q <= edge_flag_d;
            irq_mask_q  <= irq_mask_d;
            raise_q     <= raise_d;
            drive_en_q  <= drive_en_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign BUS_DATA            = drive_en_q ? rd_data_q : 8'hZZ;
    assign BUS_INTERRUPT_RAISE = raise_q;

endmodule

// File: tb/tb_bus_input_port.sv
// Self-checking bench for bus_input_port: directed scenarios then randomized operations
// compared against an abstract model of stable inputs, flags, mask and interrupt.
module tb_bus_input_port;

    localparam logic [7:0] BASE = 8'hC4;
    localparam int         SETTLE = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr = 8'h00;
    logic        we = 1'b0;
    logic [15:0] sw = 16'h0000;
    logic [3:0]  btn = 4'h0;
    logic        ack = 1'b0;
    logic        raise;
    logic        tb_drv = 1'b0;
    logic [7:0]  tb_wdata = 8'h00;
    wire  [7:0]  bus_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side bus driver; the pull-ups make a released bus read as 8'hFF
    assign bus_data = tb_drv ? tb_wdata : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (bus_data[g]);
    end

    always #5 clk = ~clk;

    bus_input_port #(.BASE_ADDR(BASE), .DEBOUNCE_DIV(4), .DEBOUNCE_SAMPLES(3)) dut (
        .CLK(clk), .RESET(rst), .BUS_ADDR(addr), .BUS_DATA(bus_data), .BUS_WE(we),
        .SWITCHES(sw), .BUTTONS(btn), .BUS_INTERRUPT_RAISE(raise), .BUS_INTERRUPT_ACK(ack)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge
    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        addr = a;
        we   = 1'b0;
        @(negedge clk);
        d    = bus_data;
        addr = 8'h00;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        addr     = a;
        we       = 1'b1;
        tb_drv   = 1'b1;
        tb_wdata = d;
        @(negedge clk);
        we     = 1'b0;
        tb_drv = 1'b0;
        addr   = 8'h00;
        @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check_eq(tag, d, exp);
    endtask

    task automatic settle();
        repeat (SETTLE) @(negedge clk);
    endtask

    // Reset with the given raw inputs; returns just after the falling edge where reset drops
    task automatic do_reset(input logic [3:0] b_after);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        btn = b_after;
    endtask

    logic [15:0] sw_m;
    logic [3:0]  btn_m, flag_m, mask_m, nb, pressed;
    logic        raise_m;
    logic [7:0]  rd, wd;
    int          op;

    initial begin
        // Reset and idle bus
        do_reset(4'h0);
        @(negedge clk);
        check_eq("rst_raise", {7'b0, raise}, 8'h00);
        check_eq("rst_bus_idle", bus_data, 8'hFF);
        read_check("rst_mask", BASE + 8'd3, 8'h0F);
        read_check("out_of_range", 8'hC0, 8'hFF);
        read_check("rst_btn", BASE + 8'd2, 8'h00);
        read_check("rst_sw_lo", BASE, 8'h00);

        // Switch debounce and glitch rejection
        sw = 16'hA55A;
        settle();
        read_check("sw_lo", BASE, 8'h5A);
        read_check("sw_hi", BASE + 8'd1, 8'hA5);
        sw = 16'hA55B;
        @(negedge clk);
        sw = 16'hA55A;
        settle();
        read_check("sw_glitch", BASE, 8'h5A);

        // Button edge, interrupt, acknowledge
        btn = 4'b0100;
        settle();
        read_check("btn2_flag", BASE + 8'd2, 8'h44);
        check_eq("btn2_raise", {7'b0, raise}, 8'h01);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check_eq("ack_raise", {7'b0, raise}, 8'h00);
        read_check("ack_flag_kept", BASE + 8'd2, 8'h44);

        // Write-1-to-clear
        bus_write(BASE + 8'd2, 8'h40);
        read_check("w1c", BASE + 8'd2, 8'h04);
        btn = 4'h0;
        settle();
        read_check("btn_release", BASE + 8'd2, 8'h00);
        bus_write(BASE, 8'hFF);
        read_check("wr_sw_ignored", BASE, 8'h5A);

        // Masking
        bus_write(BASE + 8'd3, 8'h0E);
        read_check("mask_rd", BASE + 8'd3, 8'h0E);
        btn = 4'b0001;
        settle();
        read_check("masked_flag", BASE + 8'd2, 8'h11);
        check_eq("masked_raise", {7'b0, raise}, 8'h00);

        // W1C coincident with a new edge: with the tick counter restarted by reset,
        // the edge is detected at the 14th rising edge after release
        do_reset(4'b0001);
        repeat (13) @(posedge clk);
        @(negedge clk);
        addr = BASE + 8'd2; we = 1'b1; tb_drv = 1'b1; tb_wdata = 8'h10;
        @(negedge clk);
        addr = 8'h00; we = 1'b0; tb_drv = 1'b0;
        read_check("w1c_vs_edge", BASE + 8'd2, 8'h11);
        check_eq("w1c_vs_edge_raise", {7'b0, raise}, 8'h01);

        // ACK coincident with a masked edge
        do_reset(4'b0010);
        repeat (13) @(posedge clk);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check_eq("ack_vs_edge_raise", {7'b0, raise}, 8'h01);
        read_check("ack_vs_edge_flag", BASE + 8'd2, 8'h22);

        // Randomized operations against the abstract model
        settle();
        sw_m = sw; btn_m = 4'b0010; flag_m = 4'b0010; mask_m = 4'hF; raise_m = 1'b1;
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 4));
            wd = 8'($urandom);
            case (op)
                0: begin
                    sw = 16'($urandom);
                    sw_m = sw;
                end
                1: begin
                    nb = 4'($urandom);
                    pressed = nb & ~btn_m;
                    flag_m = flag_m | pressed;
                    if ((pressed & mask_m) != 4'h0) raise_m = 1'b1;
                    btn = nb;
                    btn_m = nb;
                end
                2: begin
                    bus_write(BASE + 8'd2, wd);
                    flag_m = flag_m & ~wd[7:4];
                end
                3: begin
                    bus_write(BASE + 8'd3, wd);
                    mask_m = wd[3:0];
                end
                default: begin
                    ack = 1'b1;
                    @(negedge clk);
                    ack = 1'b0;
                    raise_m = 1'b0;
                end
            endcase
            settle();
            read_check("rnd_sw_lo", BASE, sw_m[7:0]);
            read_check("rnd_sw_hi", BASE + 8'd1, sw_m[15:8]);
            read_check("rnd_btn", BASE + 8'd2, {flag_m, btn_m});
            read_check("rnd_mask", BASE + 8'd3, {4'h0, mask_m});
            check_eq("rnd_raise", {7'b0, raise}, {7'b0, raise_m});
        end

        // Reset mid-read releases the bus on the same edge and drops the interrupt
        addr = BASE + 8'd3;
        we   = 1'b0;
        @(negedge clk);
        check_eq("read_driving", bus_data, {4'h0, mask_m});
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_release", bus_data, 8'hFF);
        check_eq("rst_mid_raise", {7'b0, raise}, 8'h00);
        addr = 8'h00;
        rst  = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
